// File: rtl/iob_slave_port.sv
// iob_slave_port: CPU-side slave port onto the slow I/O bus.
// Posts a single write (CPU released at once), stalls reads until the
// I/O bus master acks, and times out requests the master never answers.
module iob_slave_port #(
   parameter int TO_W   = 8,
   parameter int TO_CYC = 200
) (
   input  logic FCLK,
   input  logic RST,
   input  logic BACT,
   input  logic IOSel,
   input  logic IOWE,
   input  logic IOACK,
   input  logic IOBERRi,
   output logic IOREQ,
   output logic IORW,
   output logic IOWRLE,
   output logic IORDLE,
   output logic Ready,
   output logic BERR,
   output logic WrErr
);
   typedef enum logic [1:0] {IDLE, WAITPOST, RDREQ, HOLD} state_t;

   state_t          state;
   logic            done;       // current CPU cycle already started
   logic            post_busy;  // a posted write is outstanding
   logic            aborted;    // CPU dropped BACT while we were still busy
   logic            ready_q;
   logic            berr_q;
   logic [TO_W-1:0] to_cnt;

   logic ack, tmo, start, cyc_gone, issue;

   // IOACK only counts against a live request; an ack on the timeout edge wins
   assign ack      = IOACK & IOREQ;
   assign tmo      = IOREQ & ~IOACK & (to_cnt == TO_W'(TO_CYC - 1));
   assign start    = (state == IDLE) & BACT & IOSel & ~done;
   assign cyc_gone = aborted | ~BACT;
   // issue from IDLE directly, or from WAITPOST once the post buffer frees up
   assign issue    = ~post_busy & (start | ((state == WAITPOST) & ~cyc_gone));

   // Ready/BERR must never show while the CPU cycle is gone
   assign Ready = ready_q & BACT;
   assign BERR  = berr_q & BACT;

   // Request handshake, post buffer tracking and cycle FSM
   always_ff @(posedge FCLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         done      <= 1'b0;
         post_busy <= 1'b0;
         aborted   <= 1'b0;
         ready_q   <= 1'b0;
         berr_q    <= 1'b0;
         to_cnt    <= '0;
         IOREQ     <= 1'b0;
         IORW      <= 1'b0;
         IOWRLE    <= 1'b0;
         IORDLE    <= 1'b0;
         WrErr     <= 1'b0;
      end else begin
         IOWRLE <= 1'b0;
         IORDLE <= 1'b0;

         if (!BACT)      done <= 1'b0;
         else if (start) done <= 1'b1;

         if (IOREQ) to_cnt <= to_cnt + TO_W'(1);

         // request completion, common to posted writes and reads
         if (ack || tmo) begin
            IOREQ <= 1'b0;
            if (!IORW) begin
               post_busy <= 1'b0;
               if ((ack && IOBERRi) || tmo) WrErr <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               aborted <= 1'b0;
               if (start && post_busy) state <= WAITPOST;
            end
            WAITPOST: begin
               if (!BACT) aborted <= 1'b1;
               // aborted cycle: the pending write drains, then drop the access
               if (!post_busy && cyc_gone) state <= IDLE;
            end
            RDREQ: begin
               if (!BACT) aborted <= 1'b1;
               if (ack || tmo) begin
                  IORDLE <= ack;
                  if (cyc_gone) begin
                     state <= IDLE;
                  end else begin
                     ready_q <= 1'b1;
                     berr_q  <= (ack && IOBERRi) || tmo;
                     state   <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!BACT) begin
                  ready_q <= 1'b0;
                  berr_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // new request; IOREQ is always low here so nothing above conflicts
         if (issue) begin
            IOREQ  <= 1'b1;
            to_cnt <= '0;
            if (IOWE) begin
               IORW      <= 1'b0;
               IOWRLE    <= 1'b1;
               post_busy <= 1'b1;
               ready_q   <= 1'b1;
               berr_q    <= 1'b0;
               state     <= HOLD;
            end else begin
               IORW  <= 1'b1;
               state <= RDREQ;
            end
         end
      end
   end
endmodule

// File: tb/tb_iob_slave_port.sv
// Bench for iob_slave_port: directed scenarios plus a randomized run
// checked against a transaction-level model of the post buffer.
module tb_iob_slave_port;
   logic FCLK = 1'b0, RST = 1'b1;
   logic BACT = 1'b0, IOSel = 1'b0, IOWE = 1'b0, IOACK = 1'b0, IOBERRi = 1'b0;
   logic IOREQ, IORW, IOWRLE, IORDLE, Ready, BERR, WrErr;

   int n_chk = 0, n_fail = 0;

   // randomized-run model: post buffer occupancy, sticky error, master state
   bit m_post, m_wrerr, m_req_w, sched;
   int lat_left;

   iob_slave_port #(.TO_W(8), .TO_CYC(200)) dut (
      .FCLK(FCLK), .RST(RST), .BACT(BACT), .IOSel(IOSel), .IOWE(IOWE),
      .IOACK(IOACK), .IOBERRi(IOBERRi), .IOREQ(IOREQ), .IORW(IORW),
      .IOWRLE(IOWRLE), .IORDLE(IORDLE), .Ready(Ready), .BERR(BERR), .WrErr(WrErr)
   );

   always #5 FCLK = ~FCLK;

   task automatic tick;
      @(posedge FCLK);
      #1;
   endtask

   task automatic start_cyc(input bit wr);
      BACT = 1'b1; IOSel = 1'b1; IOWE = wr;
   endtask

   task automatic end_cyc;
      BACT = 1'b0; IOSel = 1'b0; IOWE = 1'b0;
   endtask

   task automatic test_reset;
      tick; tick;
      n_chk++;
      if ({IOREQ, IORW, IOWRLE, IORDLE, Ready, BERR, WrErr} !== 7'b0) begin
         n_fail++; $display("FAIL reset_hold outs=%b exp 0000000", {IOREQ, IORW, IOWRLE, IORDLE, Ready, BERR, WrErr});
      end
      #2 RST = 1'b0;
      tick;
      n_chk++;
      if ({IOREQ, IORW, IOWRLE, IORDLE, Ready, BERR, WrErr} !== 7'b0) begin
         n_fail++; $display("FAIL reset_release outs=%b exp 0000000", {IOREQ, IORW, IOWRLE, IORDLE, Ready, BERR, WrErr});
      end
   endtask

   task automatic test_post_write;
      int d;
      bit bad;
      d = $urandom_range(4, 30);
      start_cyc(1); tick;  // edge 0
      n_chk++;
      if ({Ready, IOWRLE, IOREQ, IORW, BERR} !== 5'b11100) begin
         n_fail++; $display("FAIL wr_start Ready,IOWRLE,IOREQ,IORW,BERR=%b exp 11100", {Ready, IOWRLE, IOREQ, IORW, BERR});
      end
      tick;  // edge 1
      n_chk++;
      if ({Ready, IOWRLE} !== 2'b10) begin
         n_fail++; $display("FAIL wr_hold Ready,IOWRLE=%b exp 10", {Ready, IOWRLE});
      end
      end_cyc; tick;  // edge 2
      n_chk++;
      if (Ready !== 1'b0) begin n_fail++; $display("FAIL wr_release Ready=%b exp 0", Ready); end
      bad = 0;
      for (int e = 3; e < d; e++) begin tick; if (IOREQ !== 1'b1) bad = 1; end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL wr_req_held IOREQ dropped before ack at edge %0d", d); end
      IOACK = 1'b1; tick; IOACK = 1'b0;  // edge d
      n_chk++;
      if ({IOREQ, WrErr} !== 2'b00) begin
         n_fail++; $display("FAIL wr_ack IOREQ,WrErr=%b exp 00", {IOREQ, WrErr});
      end
   endtask

   task automatic test_read(input int lat, input bit be);
      bit bad;
      start_cyc(0); tick;  // edge 0
      n_chk++;
      if ({IOREQ, IORW, Ready} !== 3'b110) begin
         n_fail++; $display("FAIL rd_start IOREQ,IORW,Ready=%b exp 110", {IOREQ, IORW, Ready});
      end
      bad = 0;
      for (int e = 1; e < lat; e++) begin tick; if (Ready !== 1'b0 || IOREQ !== 1'b1) bad = 1; end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL rd_wait Ready early or IOREQ dropped, lat=%0d", lat); end
      IOACK = 1'b1; IOBERRi = be; tick; IOACK = 1'b0; IOBERRi = 1'b0;  // edge lat
      n_chk++;
      if ({Ready, BERR, IORDLE, IOREQ} !== {1'b1, be, 2'b10}) begin
         n_fail++; $display("FAIL rd_ack Ready,BERR,IORDLE,IOREQ=%b exp %b", {Ready, BERR, IORDLE, IOREQ}, {1'b1, be, 2'b10});
      end
      tick;
      n_chk++;
      if ({Ready, BERR, IORDLE} !== {1'b1, be, 1'b0}) begin
         n_fail++; $display("FAIL rd_hold Ready,BERR,IORDLE=%b exp %b", {Ready, BERR, IORDLE}, {1'b1, be, 1'b0});
      end
      end_cyc; tick;
      n_chk++;
      if ({Ready, BERR} !== 2'b00) begin
         n_fail++; $display("FAIL rd_release Ready,BERR=%b exp 00", {Ready, BERR});
      end
   endtask

   task automatic test_back_to_back;
      bit bad;
      int lat;
      start_cyc(1); tick;  // edge 0
      n_chk++;
      if ({Ready, IOWRLE} !== 2'b11) begin n_fail++; $display("FAIL b2b_wr Ready,IOWRLE=%b exp 11", {Ready, IOWRLE}); end
      end_cyc; tick;       // edge 1
      start_cyc(0); tick;  // edge 2: read must wait for the post buffer
      bad = 0;
      for (int e = 3; e < 20; e++) begin tick; if (IORW !== 1'b0 || IOREQ !== 1'b1 || Ready !== 1'b0) bad = 1; end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL b2b_wait read issued or Ready early before write ack"); end
      IOACK = 1'b1; tick; IOACK = 1'b0;  // edge 20
      n_chk++;
      if ({IOREQ, Ready} !== 2'b00) begin n_fail++; $display("FAIL b2b_wrack IOREQ,Ready=%b exp 00", {IOREQ, Ready}); end
      tick;  // edge 21
      n_chk++;
      if ({IOREQ, IORW, Ready} !== 3'b110) begin
         n_fail++; $display("FAIL b2b_rdissue IOREQ,IORW,Ready=%b exp 110", {IOREQ, IORW, Ready});
      end
      lat = $urandom_range(2, 15);
      bad = 0;
      for (int e = 1; e < lat; e++) begin tick; if (Ready !== 1'b0) bad = 1; end
      n_chk++;
      if (bad) begin n_fail++; $display("FAIL b2b_rdwait Ready before read ack"); end
      IOACK = 1'b1; tick; IOACK = 1'b0;
      n_chk++;
      if ({Ready, BERR, IORDLE} !== 3'b101) begin
         n_fail++; $display("FAIL b2b_rdack Ready,BERR,IORDLE=%b exp 101", {Ready, BERR, IORDLE});
      end
      end_cyc; tick;
   endtask

   task automatic test_timeout;
      // read never acked
      start_cyc(0); tick;
      for (int e = 1; e < 200; e++) tick;
      n_chk++;
      if ({IOREQ, Ready} !== 2'b10) begin n_fail++; $display("FAIL to_rd199 IOREQ,Ready=%b exp 10", {IOREQ, Ready}); end
      tick;  // edge 200
      n_chk++;
      if ({IOREQ, Ready, BERR, IORDLE} !== 4'b0110) begin
         n_fail++; $display("FAIL to_rd200 IOREQ,Ready,BERR,IORDLE=%b exp 0110", {IOREQ, Ready, BERR, IORDLE});
      end
      end_cyc; tick;
      n_chk++;
      if ({Ready, BERR} !== 2'b00) begin n_fail++; $display("FAIL to_rd_release Ready,BERR=%b exp 00", {Ready, BERR}); end
      // ack on the timeout edge wins
      start_cyc(0); tick;
      for (int e = 1; e < 200; e++) tick;
      IOACK = 1'b1; tick; IOACK = 1'b0;
      n_chk++;
      if ({Ready, BERR, IORDLE} !== 3'b101) begin
         n_fail++; $display("FAIL to_ack_wins Ready,BERR,IORDLE=%b exp 101", {Ready, BERR, IORDLE});
      end
      end_cyc; tick;
      // posted write never acked
      start_cyc(1); tick;
      end_cyc;
      for (int e = 1; e < 200; e++) tick;
      n_chk++;
      if ({IOREQ, WrErr} !== 2'b10) begin n_fail++; $display("FAIL to_wr199 IOREQ,WrErr=%b exp 10", {IOREQ, WrErr}); end
      tick;
      n_chk++;
      if ({IOREQ, WrErr} !== 2'b01) begin n_fail++; $display("FAIL to_wr200 IOREQ,WrErr=%b exp 01", {IOREQ, WrErr}); end
      start_cyc(1); tick;  // buffer free again: posts immediately
      n_chk++;
      if ({Ready, IOWRLE, IOREQ} !== 3'b111) begin
         n_fail++; $display("FAIL to_wr_repost Ready,IOWRLE,IOREQ=%b exp 111", {Ready, IOWRLE, IOREQ});
      end
      end_cyc; IOACK = 1'b1; tick; IOACK = 1'b0;
   endtask

   task automatic test_rst_mid_read;
      start_cyc(0); tick; tick; tick;
      #3 RST = 1'b1;
      #1;
      n_chk++;
      if ({IOREQ, IORW, IOWRLE, IORDLE, Ready, BERR, WrErr} !== 7'b0) begin
         n_fail++; $display("FAIL rst_async outs=%b exp 0000000", {IOREQ, IORW, IOWRLE, IORDLE, Ready, BERR, WrErr});
      end
      end_cyc; tick;
      #2 RST = 1'b0;
      tick;
      IOACK = 1'b1; tick; IOACK = 1'b0;  // late ack from the abandoned request
      n_chk++;
      if ({IOREQ, IORDLE, Ready, WrErr} !== 4'b0) begin
         n_fail++; $display("FAIL rst_late_ack IOREQ,IORDLE,Ready,WrErr=%b exp 0000", {IOREQ, IORDLE, Ready, WrErr});
      end
      test_read($urandom_range(2, 12), 1'b0);
   endtask

   task automatic test_wrerr;
      start_cyc(1); tick; end_cyc; tick; tick;
      IOACK = 1'b1; IOBERRi = 1'b1; tick; IOACK = 1'b0; IOBERRi = 1'b0;
      n_chk++;
      if ({WrErr, IOREQ} !== 2'b10) begin n_fail++; $display("FAIL wrerr_set WrErr,IOREQ=%b exp 10", {WrErr, IOREQ}); end
      test_read(5, 1'b0);
      start_cyc(1); tick;
      n_chk++;
      if ({Ready, BERR} !== 2'b10) begin n_fail++; $display("FAIL wrerr_next_wr Ready,BERR=%b exp 10", {Ready, BERR}); end
      end_cyc; IOACK = 1'b1; tick; IOACK = 1'b0;
      n_chk++;
      if (WrErr !== 1'b1) begin n_fail++; $display("FAIL wrerr_sticky WrErr=%b exp 1", WrErr); end
   endtask

   task automatic test_abort;
      bit bad;
      start_cyc(0); tick;
      end_cyc;
      bad = 0;
      for (int e = 1; e < 5; e++) begin tick; if (Ready !== 1'b0 || BERR !== 1'b0) bad = 1; end
      IOACK = 1'b1; IOBERRi = 1'b1; tick; IOACK = 1'b0; IOBERRi = 1'b0;
      n_chk++;
      if (bad || {Ready, BERR, IORDLE, IOREQ} !== 4'b0010) begin
         n_fail++; $display("FAIL abort_done Ready,BERR,IORDLE,IOREQ=%b exp 0010 early=%0d", {Ready, BERR, IORDLE, IOREQ}, bad);
      end
      tick;
      start_cyc(0); tick;
      n_chk++;
      if ({IOREQ, IORW, Ready} !== 3'b110) begin
         n_fail++; $display("FAIL abort_restart IOREQ,IORW,Ready=%b exp 110", {IOREQ, IORW, Ready});
      end
      IOACK = 1'b1; tick; IOACK = 1'b0;
      n_chk++;
      if ({Ready, BERR} !== 2'b10) begin n_fail++; $display("FAIL abort_next_rd Ready,BERR=%b exp 10", {Ready, BERR}); end
      end_cyc; tick;
   endtask

   // one clock with the bench playing the I/O master; reports what was acked
   task automatic mtick(output bit ack_w, output bit ack_r, output bit ack_e);
      bit drive;
      ack_w = 0; ack_r = 0; ack_e = 0; drive = 0;
      if (IOREQ === 1'b1 && !sched) begin sched = 1; lat_left = $urandom_range(0, 10); end
      if (sched && lat_left == 0) begin
         drive = 1; IOACK = 1'b1; IOBERRi = ($urandom_range(0, 3) == 0);
      end else if (sched) begin
         lat_left--;
      end
      tick;
      if (drive) begin
         ack_e = IOBERRi;
         if (m_req_w) begin m_post = 0; if (IOBERRi) m_wrerr = 1; ack_w = 1; end
         else ack_r = 1;
         sched = 0; IOACK = 1'b0; IOBERRi = 1'b0;
      end
   endtask

   task automatic test_random;
      bit w, issued, got, pb, exp_r, exp_be, aw, ar, ae;
      int cyc;
      #2 RST = 1'b1; #2 RST = 1'b0;
      m_post = 0; m_wrerr = 0; m_req_w = 0; sched = 0; lat_left = 0;
      for (int t = 0; t < 40; t++) begin
         w = $urandom_range(0, 1);
         start_cyc(w);
         issued = 0; got = 0; cyc = 0; exp_be = 0;
         while (!got && cyc < 100) begin
            pb = m_post;
            mtick(aw, ar, ae);
            cyc++;
            exp_r = 0;
            if (!issued && !pb) begin
               issued = 1;
               m_req_w = w;
               if (w) begin m_post = 1; exp_r = 1; exp_be = 0; end
            end else if (issued && !w && ar) begin
               exp_r = 1; exp_be = ae;
            end
            n_chk++;
            if (Ready !== exp_r || (exp_r && BERR !== exp_be)) begin
               n_fail++; $display("FAIL rand_t%0d_c%0d wr=%0d Ready=%b BERR=%b exp %b %b", t, cyc, w, Ready, BERR, exp_r, exp_be);
            end
            got = exp_r;
         end
         n_chk++;
         if (!got || WrErr !== m_wrerr) begin
            n_fail++; $display("FAIL rand_t%0d_end done=%0d WrErr=%b exp %b", t, got, WrErr, m_wrerr);
         end
         end_cyc;
         for (int k = $urandom_range(1, 3); k > 0; k--) mtick(aw, ar, ae);
         n_chk++;
         if ({Ready, BERR} !== 2'b00) begin n_fail++; $display("FAIL rand_t%0d_release Ready,BERR=%b exp 00", t, {Ready, BERR}); end
      end
   endtask

   initial begin
      test_reset;
      test_post_write;
      test_read(10, 1'b0);
      test_read($urandom_range(2, 30), 1'b1);
      test_read($urandom_range(2, 30), 1'($urandom_range(0, 1)));
      test_back_to_back;
      test_timeout;
      test_rst_mid_read;
      test_wrerr;
      test_abort;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
